// File: rtl/hazard_scoreboard.sv
// Hazard/stall controller beside ID: load-use, branch-in-ID and mult/div busy.
// Drives IF/ID freeze, ID/EX bubble and a saturating stall-cycle counter.
module hazard_scoreboard #(
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 1,
  parameter int MD_LAT   = 32,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             E_MemtoReg,
  input  logic             E_RegWrite,
  input  logic [REG_W-1:0] E_WriteReg,
  input  logic             E_StartMD,
  input  logic [REG_W-1:0] Rs,
  input  logic [REG_W-1:0] Rt,
  input  logic             D_UsesRs,
  input  logic             D_UsesRt,
  input  logic             D_Branch,
  input  logic             D_UsesHiLo,
  output logic             stall,
  output logic             flush_e,
  output logic             load_use,
  output logic             branch_haz,
  output logic             md_haz,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int MD_W = $clog2(MD_LAT + 1);

  logic [LOAD_LAT-1:0] pv;
  logic [REG_W-1:0]    pd [LOAD_LAT];
  logic [LOAD_LAT-1:0] hit;
  logic                e_hit;
  logic [MD_W-1:0]     md_cnt;

  assign e_hit = (E_WriteReg != '0) &&
                 ((D_UsesRs && E_WriteReg == Rs) ||
                  (D_UsesRt && E_WriteReg == Rt));

  // Pipe advances every cycle; on a stall EX already holds a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      pv <= '0;
    end else begin
      pv[0] <= E_MemtoReg && E_RegWrite;
      for (int i = 1; i < LOAD_LAT; i++)
        pv[i] <= pv[i-1];
    end
    pd[0] <= E_WriteReg;
    for (int i = 1; i < LOAD_LAT; i++)
      pd[i] <= pd[i-1];
  end

  always_comb begin
    for (int i = 0; i < LOAD_LAT; i++)
      hit[i] = pv[i] && (pd[i] != '0) &&
               ((D_UsesRs && pd[i] == Rs) ||
                (D_UsesRt && pd[i] == Rt));
  end

  // ALU consumers clear one slot before branches do.
  always_comb begin
    load_use   = E_MemtoReg && E_RegWrite && e_hit;
    branch_haz = E_RegWrite && e_hit;
    for (int i = 0; i < LOAD_LAT; i++) begin
      if (hit[i]) begin
        branch_haz = 1'b1;
        if (i < LOAD_LAT - 1)
          load_use = 1'b1;
      end
    end
    branch_haz = branch_haz && D_Branch;
  end

  always_ff @(posedge clk) begin
    if (rst)
      md_cnt <= '0;
    else if (E_StartMD)
      md_cnt <= MD_W'(MD_LAT);
    else if (md_cnt != '0)
      md_cnt <= md_cnt - 1'b1;
  end

  assign md_busy = (md_cnt != '0);
  assign md_haz  = D_UsesHiLo && md_busy;
  assign stall   = load_use | branch_haz | md_haz;
  assign flush_e = stall;

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (stall && stall_cnt != '1)
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule
